// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, default widths and standard
// clocks-per-bit constants at 25 MHz.
package uart_pkg;

    localparam int DEF_PERIOD_W   = 20;
    localparam int DEF_MIN_PERIOD = 4;

    // Clocks per bit at 25 MHz for the standard rates.
    localparam int CPB_110    = 227272;
    localparam int CPB_300    = 83333;
    localparam int CPB_1200   = 20833;
    localparam int CPB_9600   = 2604;
    localparam int CPB_19200  = 1302;
    localparam int CPB_57600  = 434;
    localparam int CPB_115200 = 217;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        CLEANUP
    } tx_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..period-1 while running, flags the last cycle.
// Shared between the variable-rate transmitter and receiver.
module uart_bit_timer #(
    parameter int PERIOD_W = 20
) (
    input  logic                i_Clk,
    input  logic                i_Rst_L,
    input  logic                load,
    input  logic                run,
    input  logic [PERIOD_W-1:0] period,
    output logic                bit_end
);

    localparam logic [PERIOD_W-1:0] ONE = PERIOD_W'(1);

    logic [PERIOD_W-1:0] count;

    assign bit_end = run && (count == period - ONE);

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (run) begin
            count <= bit_end ? '0 : count + ONE;
        end
    end

endmodule

// File: rtl/variable_rate_uart_tx.sv
// 8N1 UART transmitter with a run-time bit period (clocks per bit),
// latched and clamped at the start of each frame.
module variable_rate_uart_tx
    import uart_pkg::*;
#(
    parameter int PERIOD_W   = DEF_PERIOD_W,
    parameter int MIN_PERIOD = DEF_MIN_PERIOD
) (
    input  logic                i_Clk,
    input  logic                i_Rst_L,
    input  logic [PERIOD_W-1:0] i_Period,
    input  logic                i_TX_DV,
    input  logic [7:0]          i_TX_Byte,
    output logic                o_TX_Active,
    output logic                o_TX_Serial,
    output logic                o_TX_Done
);

    localparam logic [PERIOD_W-1:0] MIN_P = PERIOD_W'(MIN_PERIOD);

    tx_state_t           state, next_state;
    logic [7:0]          shift;
    logic [2:0]          bit_idx;
    logic [PERIOD_W-1:0] period_q;
    logic                accept;
    logic                running;
    logic                bit_end;

    assign accept  = (state == IDLE) && i_TX_DV;
    assign running = (state == START) || (state == DATA) || (state == STOP);

    uart_bit_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_timer (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .load    (accept),
        .run     (running),
        .period  (period_q),
        .bit_end (bit_end)
    );

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state    <= IDLE;
            shift    <= '0;
            bit_idx  <= '0;
            period_q <= MIN_P;
        end else begin
            state <= next_state;
            if (accept) begin
                shift    <= i_TX_Byte;
                bit_idx  <= '0;
                period_q <= (i_Period < MIN_P) ? MIN_P : i_Period;
            end else if ((state == DATA) && bit_end) begin
                shift   <= shift >> 1;
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

    always_comb begin
        next_state  = state;
        o_TX_Serial = 1'b1;
        o_TX_Done   = 1'b0;
        o_TX_Active = running;
        case (state)
            IDLE: begin
                if (i_TX_DV) next_state = START;
            end
            START: begin
                o_TX_Serial = 1'b0;
                if (bit_end) next_state = DATA;
            end
            DATA: begin
                o_TX_Serial = shift[0];
                if (bit_end && (bit_idx == 3'd7)) next_state = STOP;
            end
            STOP: begin
                // Done coincides with the final stop-bit cycle.
                o_TX_Done = bit_end;
                if (bit_end) next_state = CLEANUP;
            end
            CLEANUP: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_variable_rate_uart_tx.sv
// Self-checking bench: every frame is compared cycle by cycle against the
// expected 10-slot line pattern derived from the byte and clamped period.
module tb_variable_rate_uart_tx;

    logic        i_Clk = 1'b0;
    logic        i_Rst_L = 1'b0;
    logic [19:0] i_Period = '0;
    logic        i_TX_DV = 1'b0;
    logic [7:0]  i_TX_Byte = '0;
    logic        o_TX_Active;
    logic        o_TX_Serial;
    logic        o_TX_Done;

    int total = 0;
    int bad   = 0;

    variable_rate_uart_tx dut (
        .i_Clk       (i_Clk),
        .i_Rst_L     (i_Rst_L),
        .i_Period    (i_Period),
        .i_TX_DV     (i_TX_DV),
        .i_TX_Byte   (i_TX_Byte),
        .o_TX_Active (o_TX_Active),
        .o_TX_Serial (o_TX_Serial),
        .o_TX_Done   (o_TX_Done)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Sends one frame and checks every cycle of it plus the cleanup cycle.
    // hold keeps i_TX_DV high with junk bytes while busy; those must be ignored.
    task automatic run_frame(input logic [7:0] b, input int req, input bit hold);
        int         p;
        logic [9:0] slots;
        p     = (req < 4) ? 4 : req;
        slots = {1'b1, b, 1'b0};
        @(negedge i_Clk);
        chk("idle_line", o_TX_Serial, 1);
        chk("idle_active", o_TX_Active, 0);
        i_TX_DV   = 1'b1;
        i_TX_Byte = b;
        i_Period  = req[19:0];
        for (int i = 1; i <= 10 * p; i++) begin
            @(negedge i_Clk);
            chk("line", o_TX_Serial, slots[(i - 1) / p]);
            chk("active", o_TX_Active, 1);
            chk("done", o_TX_Done, (i == 10 * p) ? 1 : 0);
            i_TX_DV   = hold;
            i_TX_Byte = 8'($urandom);
            i_Period  = 20'($urandom_range(0, 300));
        end
        @(negedge i_Clk);
        chk("cleanup_line", o_TX_Serial, 1);
        chk("cleanup_active", o_TX_Active, 0);
        chk("cleanup_done", o_TX_Done, 0);
    endtask

    initial begin
        #1;
        chk("rst_line", o_TX_Serial, 1);
        chk("rst_active", o_TX_Active, 0);
        chk("rst_done", o_TX_Done, 0);
        repeat (3) @(negedge i_Clk);
        i_Rst_L = 1'b1;

        run_frame(8'hA5, 4, 1'b0);
        run_frame(8'h00, 0, 1'b0);
        run_frame(8'hFF, 3, 1'b0);
        run_frame(8'h55, 217, 1'b0);
        run_frame(8'($urandom), 10, 1'b0);

        // Back-to-back requests: only IDLE samples are accepted.
        run_frame(8'h96, 8, 1'b1);
        run_frame(8'h3E, 8, 1'b1);
        run_frame(8'h71, 8, 1'b0);

        // Reset in the middle of data bit 3 at P=16.
        @(negedge i_Clk);
        i_TX_DV   = 1'b1;
        i_TX_Byte = 8'hC3;
        i_Period  = 20'd16;
        @(negedge i_Clk);
        i_TX_DV = 1'b0;
        repeat (69) @(negedge i_Clk);
        chk("pre_rst_bit3", o_TX_Serial, 0);
        chk("pre_rst_active", o_TX_Active, 1);
        #2;
        i_Rst_L = 1'b0;
        #1;
        chk("async_rst_line", o_TX_Serial, 1);
        chk("async_rst_active", o_TX_Active, 0);
        chk("async_rst_done", o_TX_Done, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge i_Clk);
            chk("rst_hold_done", o_TX_Done, 0);
            chk("rst_hold_line", o_TX_Serial, 1);
        end
        i_Rst_L = 1'b1;
        run_frame(8'h3C, 16, 1'b0);

        for (int n = 0; n < 20; n++) begin
            run_frame(8'($urandom), int'($urandom_range(0, 40)), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
